// File: rtl/uart_tx_fifo.sv
// UART transmit path: 32-bit words are unpacked big-endian into a 16-byte FIFO
// and sent as 8N1 frames; trailing 0xFF bytes of a word are padding, not data.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  output logic        tx,
  output logic        busy,
  output logic        empty,
  output logic        full
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]        r_mem [16];
  logic [3:0]        r_wr_ptr;
  logic [3:0]        r_rd_ptr;
  logic [4:0]        r_count;
  state_t            r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bit;
  logic [7:0]        r_shift;
  logic              r_tx;
  logic              r_busy;

  logic [2:0] w_nbytes;
  logic [4:0] w_add;
  logic       w_wr;
  logic       w_pop;
  logic       w_baud_done;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_nbytes = 3'd0;
    if      (write_data[7:0]   != 8'hFF) w_nbytes = 3'd4;
    else if (write_data[15:8]  != 8'hFF) w_nbytes = 3'd3;
    else if (write_data[23:16] != 8'hFF) w_nbytes = 3'd2;
    else if (write_data[31:24] != 8'hFF) w_nbytes = 3'd1;
  end

  // full is judged on the pre-edge count, so a word is either stored whole or dropped.
  assign w_wr        = write_enable && !full;
  assign w_add       = w_wr ? {2'b00, w_nbytes} : 5'd0;
  assign w_pop       = (r_state == S_IDLE) && (r_count != 5'd0);
  assign w_baud_done = (r_baud == BAUD_LAST);

  // NOTE: the byte array carries no reset; count and pointers alone define which entries are valid.
  always_ff @(posedge clk_100MHz) begin
    if (w_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < w_nbytes) r_mem[r_wr_ptr + 4'(i)] <= write_data[31-8*i -: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + w_add[3:0];
      r_count  <= r_count + w_add - {4'd0, w_pop};
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_rd_ptr <= '0;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          if (w_pop) begin
            r_shift  <= r_mem[r_rd_ptr];
            r_rd_ptr <= r_rd_ptr + 4'd1;
            r_tx     <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_START;
          end
        end
        S_START: begin
          if (w_baud_done) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        S_DATA: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              // Present the next bit on the same edge the shift register advances.
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
              r_bit   <= r_bit + 3'd1;
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        S_STOP: begin
          if (w_baud_done) begin
            r_baud  <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx    = r_tx;
  assign busy  = r_busy;
  assign empty = (r_count == 5'd0);
  assign full  = (r_count > 5'd12);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 4 clocks per bit; a line monitor decodes
// tx frames independently and each scenario task compares against fixed values.
module tb_uart_tx_fifo;

  localparam int CPB = 4;
  localparam int FRAME_PERIOD = 10 * CPB + 1;

  logic        clk_100MHz   = 1'b0;
  logic        reset        = 1'b0;
  logic [31:0] write_data   = '0;
  logic        write_enable = 1'b0;
  logic        tx;
  logic        busy;
  logic        empty;
  logic        full;

  int n_checks  = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int frame_err = 0;

  logic [7:0] rx_q[$];
  int         rx_start_q[$];
  bit         mon_active = 1'b0;
  int         mon_t;
  int         mon_start;
  logic [7:0] mon_sh;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB)) dut (
    .clk_100MHz  (clk_100MHz),
    .reset       (reset),
    .write_data  (write_data),
    .write_enable(write_enable),
    .tx          (tx),
    .busy        (busy),
    .empty       (empty),
    .full        (full)
  );

  always #5 clk_100MHz = ~clk_100MHz;
  always @(posedge clk_100MHz) cyc++;

  // Line monitor: samples at mid-bit on falling clock edges, aborts on reset.
  always @(negedge clk_100MHz) begin
    if (reset) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_t      = 0;
        mon_start  = cyc;
      end
    end else begin
      mon_t++;
      if (mon_t >= CPB + CPB/2 && mon_t < 9*CPB && (mon_t - CPB/2) % CPB == 0)
        mon_sh[(mon_t - CPB - CPB/2) / CPB] = tx;
      if (mon_t == 9*CPB + CPB/2) begin
        if (tx === 1'b1) begin
          rx_q.push_back(mon_sh);
          rx_start_q.push_back(mon_start);
        end else begin
          frame_err++;
        end
        mon_active = 1'b0;
      end
    end
  end

  task automatic wr(input logic [31:0] w);
    write_data   = w;
    write_enable = 1'b1;
    @(posedge clk_100MHz); #1;
    write_enable = 1'b0;
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_start_q.delete();
  endtask

  task automatic wait_rx(input int n, input int budget);
    int b = 0;
    while (rx_q.size() < n && b < budget) begin
      @(posedge clk_100MHz);
      b++;
    end
    #1;
  endtask

  task automatic test_reset();
    int bad = 0;
    #23;
    reset = 1'b1;
    #1;
    n_checks++; if (tx !== 1'b1)    begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
    n_checks++; if (full !== 1'b0)  begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
    repeat (2) @(posedge clk_100MHz);
    #1 reset = 1'b0;
    repeat (100) begin
      @(negedge clk_100MHz);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    @(posedge clk_100MHz); #1;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL reset_idle: got %0d active cycles expected 0", bad); end
    n_checks++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL reset_noframe: got %0d frames expected 0", rx_q.size()); end
  endtask

  task automatic test_single_byte();
    logic [7:0] b = 8'h41;
    logic       exp_tx;
    int bad_tx = 0;
    int busy_hi = 0;
    clear_rx();
    wr(32'h41FF_FFFF);
    n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL single_empty_fall: got %b expected 0", empty); end
    @(negedge clk_100MHz);
    n_checks++; if (tx !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL single_prepop: got tx=%b busy=%b expected tx=1 busy=0", tx, busy); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_100MHz);
      if (i == 0) begin
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty_at_pop: got %b expected 1", empty); end
      end
      if (i < CPB)          exp_tx = 1'b0;
      else if (i < 9 * CPB) exp_tx = b[(i - CPB) / CPB];
      else                  exp_tx = 1'b1;
      if (tx !== exp_tx) bad_tx++;
      if (busy === 1'b1) busy_hi++;
    end
    n_checks++; if (bad_tx !== 0) begin n_fail++; $display("FAIL single_wave: got %0d wrong tx cycles expected 0", bad_tx); end
    n_checks++; if (busy_hi !== 40) begin n_fail++; $display("FAIL single_busy_len: got %0d expected 40", busy_hi); end
    repeat (4) @(negedge clk_100MHz);
    n_checks++; if (busy !== 1'b0 || tx !== 1'b1) begin n_fail++; $display("FAIL single_after: got busy=%b tx=%b expected busy=0 tx=1", busy, tx); end
    @(posedge clk_100MHz); #1;
    n_checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h41) begin n_fail++; $display("FAIL single_byte: got %0d frames first=%h expected 1 frame 41", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx); end
  endtask

  task automatic test_full_word();
    logic [7:0] exp_b [4] = '{8'h31, 8'h32, 8'h33, 8'h34};
    int first = -1;
    int last = -1;
    int hi = 0;
    int bad = 0;
    clear_rx();
    wr(32'h3132_3334);
    for (int i = 0; i < 250; i++) begin
      @(negedge clk_100MHz);
      if (busy === 1'b1) begin
        if (first < 0) first = i;
        last = i;
        hi++;
      end
    end
    @(posedge clk_100MHz); #1;
    n_checks++; if (last - first + 1 !== 4 * FRAME_PERIOD - 1) begin n_fail++; $display("FAIL word_busy_span: got %0d expected %0d", last - first + 1, 4 * FRAME_PERIOD - 1); end
    n_checks++; if (hi !== 40 * 4) begin n_fail++; $display("FAIL word_busy_cycles: got %0d expected 160", hi); end
    n_checks++; if (rx_q.size() != 4) begin n_fail++; $display("FAIL word_count: got %0d expected 4", rx_q.size()); end
    for (int k = 0; k < 4 && k < rx_q.size(); k++) if (rx_q[k] !== exp_b[k]) bad++;
    for (int k = 0; k + 1 < rx_start_q.size(); k++) if (rx_start_q[k+1] - rx_start_q[k] != FRAME_PERIOD) bad++;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL word_order_spacing: got %0d errors expected 0", bad); end
    n_checks++; if (!(empty === 1'b1 && busy === 1'b0)) begin n_fail++; $display("FAIL word_drained: got empty=%b busy=%b expected 1/0", empty, busy); end
  endtask

  task automatic test_padding_full();
    logic [31:0] words [4] = '{32'hA0A1_A2A3, 32'hB0B1_B2B3, 32'hC0C1_C2C3, 32'hD0D1_D2D3};
    int bad = 0;
    clear_rx();
    wr(32'hFFFF_FFFF);
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL pad_empty: got %b expected 1", empty); end
    repeat (20) begin
      @(negedge clk_100MHz);
      if (busy !== 1'b0) bad++;
    end
    @(posedge clk_100MHz); #1;
    n_checks++; if (bad !== 0 || rx_q.size() != 0) begin n_fail++; $display("FAIL pad_noop: got %0d busy cycles %0d frames expected 0 0", bad, rx_q.size()); end
    wr(words[0]);
    wr(words[1]);
    wr(words[2]);
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL full_at_11: got %b expected 0", full); end
    wr(words[3]);
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_at_15: got %b expected 1", full); end
    wr(32'hE0E1_E2E3);
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_after_drop: got %b expected 1", full); end
    wait_rx(16, 16 * FRAME_PERIOD + 50);
    repeat (100) @(posedge clk_100MHz);
    #1;
    n_checks++; if (rx_q.size() != 16) begin n_fail++; $display("FAIL full_count: got %0d expected 16", rx_q.size()); end
    bad = 0;
    for (int j = 0; j < 16 && j < rx_q.size(); j++) if (rx_q[j] !== words[j/4][31 - 8*(j%4) -: 8]) bad++;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL full_stream: got %0d wrong bytes expected 0", bad); end
  endtask

  task automatic test_wrap();
    int bad = 0;
    int guard;
    clear_rx();
    for (int k = 0; k < 6; k++) begin
      guard = 0;
      while (full === 1'b1 && guard < 600) begin
        @(posedge clk_100MHz); #1;
        guard++;
      end
      wr({8'(4*k), 8'(4*k + 1), 8'(4*k + 2), 8'(4*k + 3)});
    end
    wait_rx(24, 24 * FRAME_PERIOD + 100);
    n_checks++; if (rx_q.size() != 24) begin n_fail++; $display("FAIL wrap_count: got %0d expected 24", rx_q.size()); end
    for (int j = 0; j < 24 && j < rx_q.size(); j++) if (rx_q[j] !== 8'(j)) bad++;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL wrap_seq: got %0d wrong bytes expected 0", bad); end
  endtask

  task automatic test_simultaneous();
    int bad = 0;
    clear_rx();
    wr(32'h61FF_FFFF);
    wr(32'h6263_6465);
    wr(32'h6667_6869);
    wr(32'h6A6B_6C6D);
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL simul_full_at_12: got %b expected 0", full); end
    wr(32'h6E6F_7071);
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL simul_full_at_16: got %b expected 1", full); end
    wait_rx(17, 17 * FRAME_PERIOD + 50);
    n_checks++; if (rx_q.size() != 17) begin n_fail++; $display("FAIL simul_count: got %0d expected 17", rx_q.size()); end
    for (int j = 0; j < 17 && j < rx_q.size(); j++) if (rx_q[j] !== 8'(8'h61 + j)) bad++;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL simul_order: got %0d wrong bytes expected 0", bad); end
  endtask

  task automatic test_reset_mid_frame();
    int bad = 0;
    repeat (60) @(posedge clk_100MHz);
    #1;
    clear_rx();
    wr(32'h5556_5758);
    repeat (18) @(posedge clk_100MHz);
    #2;
    n_checks++; if (tx !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL midframe_bit3: got tx=%b busy=%b expected 0 1", tx, busy); end
    reset = 1'b1;
    #1;
    n_checks++; if (tx !== 1'b1)    begin n_fail++; $display("FAIL midframe_tx: got %b expected 1", tx); end
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL midframe_busy: got %b expected 0", busy); end
    n_checks++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL midframe_flags: got empty=%b full=%b expected 1 0", empty, full); end
    repeat (2) @(posedge clk_100MHz);
    #1 reset = 1'b0;
    repeat (200) begin
      @(negedge clk_100MHz);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    @(posedge clk_100MHz); #1;
    n_checks++; if (bad !== 0 || rx_q.size() != 0) begin n_fail++; $display("FAIL midframe_quiet: got %0d active cycles %0d frames expected 0 0", bad, rx_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_full_word();
    test_padding_full();
    test_wrap();
    test_simultaneous();
    test_reset_mid_frame();
    n_checks++; if (frame_err !== 0) begin n_fail++; $display("FAIL stop_bits: got %0d bad stop bits expected 0", frame_err); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
